// File: rtl/spi_target.sv
// spi_target: SPI mode-0 (CPOL=0, CPHA=0) responder, MSB first, byte oriented.
// The SPI pins are oversampled in the clk domain. Received bytes land in a
// UART-style holding register. Transmit bytes come from a small TX FIFO, and
// IDLE_BYTE is sent when the FIFO is empty at a byte load point.
//
// Ports
//   clk             system clock, at least 8x the spi_sck frequency
//   Rst             synchronous reset, active-high
//   spi_sck         serial clock from the master (asynchronous)
//   spi_cs          chip select, active-low (asynchronous)
//   spi_mosi        master-out data (asynchronous)
//   spi_miso        target-out data, registered
//   tx_din/tx_wen   TX FIFO push (a push while full is dropped)
//   tx_full         TX FIFO status, registered
//   tx_empty        TX FIFO status, registered
//   rx_dout         last received byte
//   rx_data_present rx_dout holds an unread byte
//   rx_ren          read acknowledge; clears present and overrun
//   rx_overrun      sticky: a byte arrived while rx_data_present was set
//   busy            transaction in progress
//
// state  | meaning
// IDLE   | cs high or not yet seen falling; miso parked at 1
// SHIFT  | cs low; bits shift on sck edges, bytes complete every 8th rise
module spi_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TX_DEPTH    = 4,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       spi_sck,
    input  logic       spi_cs,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] tx_din,
    input  logic       tx_wen,
    output logic       tx_full,
    output logic       tx_empty,
    output logic [7:0] rx_dout,
    output logic       rx_data_present,
    input  logic       rx_ren,
    output logic       rx_overrun,
    output logic       busy
);

    localparam int unsigned PTR_W = $clog2(TX_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_hist_q, cs_hist_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_fall;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_tx_q, shreg_tx_d;
    logic [7:0] shreg_rx_q, shreg_rx_d;
    logic       miso_q, miso_d;
    logic       pop_req, byte_done;

    logic [7:0]       rx_dout_q;
    logic             rx_present_q, rx_overrun_q;

    logic [7:0]       mem_q [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             push, pop;
    logic [7:0]       head_byte;

    // Synchronizers plus one history flop per edge-detected input.
    always_ff @(posedge clk) begin
        if (Rst) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_hist_q  <= 1'b0;
            cs_hist_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_hist_q  <= sck_s;
            cs_hist_q   <= cs_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist_q;
    assign sck_fall = ~sck_s & sck_hist_q;
    assign cs_fall  = ~cs_s & cs_hist_q;

    assign head_byte = empty_q ? IDLE_BYTE : mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_tx_d = shreg_tx_q;
        shreg_rx_d = shreg_rx_q;
        pop_req    = 1'b0;
        byte_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    pop_req    = 1'b1;
                    shreg_tx_d = head_byte;
                    bit_cnt_d  = 3'd0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Deselect takes priority over a simultaneous sck rise.
                if (cs_s) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                end else if (sck_rise) begin
                    shreg_rx_d = {shreg_rx_q[6:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_done  = 1'b1;
                        pop_req    = 1'b1;
                        shreg_tx_d = head_byte;
                    end
                end else if (sck_fall && bit_cnt_q != 3'd0) begin
                    // No shift on the fall that starts a byte: bit 7 must
                    // stay on the pin for that byte's first rise.
                    shreg_tx_d = {shreg_tx_q[6:0], 1'b0};
                end
            end
            default: state_d = ST_IDLE;
        endcase
        miso_d = (state_d == ST_SHIFT) ? shreg_tx_d[7] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shreg_tx_q   <= IDLE_BYTE;
            shreg_rx_q   <= 8'h00;
            miso_q       <= 1'b1;
            rx_dout_q    <= 8'h00;
            rx_present_q <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_tx_q <= shreg_tx_d;
            shreg_rx_q <= shreg_rx_d;
            miso_q     <= miso_d;
            if (byte_done) begin
                rx_dout_q    <= shreg_rx_d;
                rx_present_q <= 1'b1;
                // An acknowledge in the completion cycle absorbs the old byte.
                if (rx_present_q && !rx_ren)
                    rx_overrun_q <= 1'b1;
            end else if (rx_ren) begin
                rx_present_q <= 1'b0;
                rx_overrun_q <= 1'b0;
            end
        end
    end

    // A push while full is dropped even when a pop frees a slot that cycle.
    assign push = tx_wen & ~full_q;
    assign pop  = pop_req & ~empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(TX_DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= tx_din;
    end

    assign spi_miso        = miso_q;
    assign tx_full         = full_q;
    assign tx_empty        = empty_q;
    assign rx_dout         = rx_dout_q;
    assign rx_data_present = rx_present_q;
    assign rx_overrun      = rx_overrun_q;
    assign busy            = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target. It runs a table of directed vectors, then randomized
// bursts checked against a queue-based reference model, then a reset
// issued in the middle of a byte.
module tb_spi_target;

    logic       clk = 1'b0;
    logic       Rst;
    logic       spi_sck, spi_cs, spi_mosi, spi_miso;
    logic [7:0] tx_din;
    logic       tx_wen, tx_full, tx_empty;
    logic [7:0] rx_dout;
    logic       rx_data_present, rx_ren, rx_overrun, busy;

    always #5 clk = ~clk;

    spi_target #(.SYNC_STAGES(2), .TX_DEPTH(4), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .Rst(Rst), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .tx_din(tx_din), .tx_wen(tx_wen), .tx_full(tx_full),
        .tx_empty(tx_empty), .rx_dout(rx_dout), .rx_data_present(rx_data_present),
        .rx_ren(rx_ren), .rx_overrun(rx_overrun), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference model. The FIFO is a queue. Every load point takes the head,
    // or 8'hFF when the queue is empty.
    logic [7:0] mq[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_present = 1'b0;
    logic       m_ovr = 1'b0;

    function automatic logic [7:0] model_pop();
        if (mq.size() == 0) return 8'hFF;
        return mq.pop_front();
    endfunction

    function automatic void model_rx(input logic [7:0] b);
        if (m_present) m_ovr = 1'b1;
        m_dout    = b;
        m_present = 1'b1;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        tx_din = b;
        tx_wen = 1'b1;
        step(1);
        tx_wen = 1'b0;
        if (mq.size() < 4) mq.push_back(b);
    endtask

    task automatic read_ack();
        rx_ren = 1'b1;
        step(1);
        rx_ren = 1'b0;
        m_present = 1'b0;
        m_ovr     = 1'b0;
    endtask

    logic [7:0] m_tx[5];
    logic [7:0] m_rx[5];
    logic [7:0] m_exp[5];

    // Master side at clk/16. Sends nfull complete bytes. When abort_rises >= 0,
    // it then gives that many rises of m_tx[nfull] and deselects.
    task automatic spi_burst(input int nfull, input int abort_rises);
        logic [7:0] cur;
        spi_cs = 1'b0;
        cur = model_pop();
        for (int b = 0; b < nfull; b++) begin
            for (int i = 7; i >= 0; i--) begin
                spi_mosi = m_tx[b][i];
                step(8);
                m_rx[b][i] = spi_miso;
                spi_sck = 1'b1;
                step(8);
                spi_sck = 1'b0;
            end
            m_exp[b] = cur;
            model_rx(m_tx[b]);
            cur = model_pop();
        end
        if (abort_rises >= 0) begin
            for (int i = 0; i < abort_rises; i++) begin
                spi_mosi = m_tx[nfull][7-i];
                step(8);
                spi_sck = 1'b1;
                step(8);
                spi_sck = 1'b0;
            end
        end
        step(8);
        spi_cs = 1'b1;
        spi_mosi = 1'b0;
        step(8);
    endtask

    typedef struct packed {
        logic [2:0]      npush;
        logic [4:0][7:0] push;      // element 0 is rightmost
        logic [2:0]      nbytes;
        logic [4:0][7:0] mosi;
        logic [3:0]      abort;     // 4'hF: no partial byte
        logic [4:0][7:0] exp_miso;
        logic [7:0]      exp_dout;
        logic            exp_present;
        logic            exp_ovr;
        logic            exp_full_push;
        logic            exp_empty;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'd1, {32'h0, 8'hA5}, 3'd1, {32'h0, 8'h3C}, 4'hF, {32'h0, 8'hA5},
                    8'h3C, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{3'd0, 40'h0, 3'd1, {32'h0, 8'h00}, 4'hF, {32'h0, 8'hFF},
                    8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{3'd3, {16'h0, 24'h332211}, 3'd3, {16'h0, 24'hC3C2C1}, 4'hF,
                    {16'h0, 24'h332211}, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{3'd2, {24'h0, 16'h5544}, 3'd0, {32'h0, 8'hF0}, 4'd5, 40'h0,
                    8'hC3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{3'd0, 40'h0, 3'd1, {32'h0, 8'h66}, 4'hF, {32'h0, 8'h55},
                    8'h66, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{3'd5, 40'h0504030201, 3'd5, 40'hE5E4E3E2E1, 4'hF, 40'hFF04030201,
                    8'hE5, 1'b1, 1'b1, 1'b1, 1'b1};

        Rst = 1'b1; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        tx_din = 8'h00; tx_wen = 1'b0; rx_ren = 1'b0;
        step(3);
        check("rst_miso", spi_miso, 1);
        check("rst_dout", rx_dout, 8'h00);
        check("rst_present", rx_data_present, 0);
        check("rst_ovr", rx_overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_empty", tx_empty, 1);
        check("rst_full", tx_full, 0);
        Rst = 1'b0;
        step(2);

        for (int v = 0; v < 6; v++) begin
            read_ack();
            step(1);
            check($sformatf("v%0d_ack_present", v), rx_data_present, 0);
            check($sformatf("v%0d_ack_ovr", v), rx_overrun, 0);
            for (int p = 0; p < int'(vecs[v].npush); p++)
                push_byte(vecs[v].push[p]);
            check($sformatf("v%0d_full_after_push", v), tx_full, vecs[v].exp_full_push);
            for (int b = 0; b < 5; b++) m_tx[b] = vecs[v].mosi[b];
            spi_burst(int'(vecs[v].nbytes), (vecs[v].abort == 4'hF) ? -1 : int'(vecs[v].abort));
            for (int b = 0; b < int'(vecs[v].nbytes); b++)
                check($sformatf("v%0d_miso%0d", v, b), m_rx[b], vecs[v].exp_miso[b]);
            check($sformatf("v%0d_dout", v), rx_dout, vecs[v].exp_dout);
            check($sformatf("v%0d_present", v), rx_data_present, vecs[v].exp_present);
            check($sformatf("v%0d_ovr", v), rx_overrun, vecs[v].exp_ovr);
            check($sformatf("v%0d_empty", v), tx_empty, vecs[v].exp_empty);
            check($sformatf("v%0d_full", v), tx_full, 0);
            check($sformatf("v%0d_busy", v), busy, 0);
            check($sformatf("v%0d_miso_idle", v), spi_miso, 1);
        end

        for (int it = 0; it < 25; it++) begin
            int np, nf, ab;
            np = $urandom_range(0, 5);
            for (int p = 0; p < np; p++) push_byte(8'($urandom));
            check($sformatf("r%0d_full", it), tx_full, (mq.size() == 4));
            if ($urandom_range(0, 1) == 1) read_ack();
            nf = $urandom_range(0, 3);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            if (nf == 0 && ab < 0) nf = 1;
            for (int b = 0; b < 5; b++) m_tx[b] = 8'($urandom);
            spi_burst(nf, ab);
            for (int b = 0; b < nf; b++)
                check($sformatf("r%0d_miso%0d", it, b), m_rx[b], m_exp[b]);
            check($sformatf("r%0d_dout", it), rx_dout, m_dout);
            check($sformatf("r%0d_present", it), rx_data_present, m_present);
            check($sformatf("r%0d_ovr", it), rx_overrun, m_ovr);
            check($sformatf("r%0d_empty", it), tx_empty, (mq.size() == 0));
            check($sformatf("r%0d_busy", it), busy, 0);
        end

        // Reset partway through a byte while two bytes are queued.
        while (mq.size() > 0) void'(mq.pop_front());
        spi_cs = 1'b0; step(8);
        m_tx[0] = 8'h5A; spi_burst(1, -1);
        push_byte(8'h12);
        push_byte(8'h34);
        spi_cs = 1'b0; spi_mosi = 1'b1;
        step(8);
        for (int i = 0; i < 3; i++) begin
            spi_sck = 1'b1; step(8); spi_sck = 1'b0; step(8);
        end
        check("mid_busy", busy, 1);
        Rst = 1'b1; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        step(1);
        check("mrst_miso", spi_miso, 1);
        check("mrst_dout", rx_dout, 8'h00);
        check("mrst_present", rx_data_present, 0);
        check("mrst_ovr", rx_overrun, 0);
        check("mrst_busy", busy, 0);
        check("mrst_empty", tx_empty, 1);
        check("mrst_full", tx_full, 0);
        Rst = 1'b0;
        mq.delete();
        m_dout = 8'h00; m_present = 1'b0; m_ovr = 1'b0;
        step(4);
        m_tx[0] = 8'hA7;
        spi_burst(1, -1);
        check("post_rst_miso", m_rx[0], 8'hFF);
        check("post_rst_dout", rx_dout, 8'hA7);
        check("post_rst_present", rx_data_present, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
